// File: rtl/jfpjc_pkg.sv
// Shared definitions for the jfpjc DCT engines: FSM states, transform size,
// default coefficient precision and the accumulator sizing rule.
package jfpjc_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, MAC, EMIT, DONE} dct_state_t;

  localparam int DCT8_N        = 8;
  localparam int DEF_COEF_FRAC = 12;

  // Sample width plus coefficient width (frac + 2) plus 4 guard bits for the 8-term sum.
  function automatic int acc_width(input int in_w, input int coef_frac);
    return in_w + coef_frac + 2 + 4;
  endfunction

endpackage

// File: rtl/dct8_coef_rom.sv
// Combinational DCT-II coefficient table C(k,n), built at elaboration from
// COEF_FRAC using $cos so that precision changes need no hand-edited constants.
module dct8_coef_rom
  import jfpjc_pkg::*;
#(
  parameter int COEF_FRAC = DEF_COEF_FRAC,
  localparam int CW = COEF_FRAC + 2
) (
  input  logic [2:0]           k,
  input  logic [2:0]           n,
  output logic signed [CW-1:0] coef
);

  logic signed [CW-1:0] coef_table [DCT8_N*DCT8_N];

  for (genvar gi = 0; gi < DCT8_N; gi++) begin : g_k
    for (genvar gj = 0; gj < DCT8_N; gj++) begin : g_n
      localparam real PI   = 3.14159265358979323846;
      localparam real CK   = (gi == 0) ? 0.70710678118654752440 : 1.0;
      localparam real VAL  = (2.0 ** COEF_FRAC) * CK / 2.0 * $cos((2 * gj + 1) * gi * PI / 16.0);
      // Round to nearest, symmetric about zero so C(k,n) and C(k,7-n) stay exact negatives.
      localparam int  IVAL = (VAL >= 0.0) ? $rtoi(VAL + 0.5) : -$rtoi(0.5 - VAL);
      assign coef_table[gi*DCT8_N + gj] = CW'(IVAL);
    end
  end

  assign coef = coef_table[{k, n}];

endmodule

// File: rtl/dct8_engine.sv
// Sequential 8-point forward DCT-II: load 8 samples, one MAC per cycle per
// coefficient, round/saturate and hand out over valid/ready. Macro: DCT8_LEVEL_SHIFT_EN.
module dct8_engine
  import jfpjc_pkg::*;
#(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 16,
  parameter int COEF_FRAC = DEF_COEF_FRAC
) (
  input  logic                        clock,
  input  logic                        nreset,
  input  logic                        start,
  output logic                        busy,
  output logic [2:0]                  fetch_addr,
  input  logic [IN_WIDTH-1:0]         fetch_data,
  output logic                        fetch_clk,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic [2:0]                  out_index,
  output logic                        done
);

  localparam int COEF_WIDTH = COEF_FRAC + 2;
  localparam int ACC_WIDTH  = acc_width(IN_WIDTH, COEF_FRAC);
`ifdef DCT8_LEVEL_SHIFT_EN
  localparam int XW = IN_WIDTH + 1;
`else
  localparam int XW = IN_WIDTH;
`endif
  localparam longint SAT_MAX_L = (longint'(1) << (OUT_WIDTH - 1)) - 1;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(SAT_MAX_L);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-SAT_MAX_L - 1);

  dct_state_t                   state;
  logic [3:0]                   cnt;
  logic signed [XW-1:0]         x [DCT8_N];
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [COEF_WIDTH-1:0] coef;
  logic signed [XW-1:0]         sample_in;
  logic signed [ACC_WIDTH-1:0]  term;
  logic signed [ACC_WIDTH-1:0]  acc_sum;
  logic signed [ACC_WIDTH-1:0]  rounded;
  logic signed [OUT_WIDTH-1:0]  y_sat;

  assign fetch_clk = clock;

`ifdef DCT8_LEVEL_SHIFT_EN
  assign sample_in = $signed({1'b0, fetch_data}) - $signed({2'b01, {(IN_WIDTH-1){1'b0}}});
`else
  assign sample_in = $signed(fetch_data);
`endif

  // out_index doubles as the coefficient number k being computed.
  dct8_coef_rom #(.COEF_FRAC(COEF_FRAC)) u_coef_rom (
    .k    (out_index),
    .n    (cnt[2:0]),
    .coef (coef)
  );

  assign term    = ACC_WIDTH'(x[cnt[2:0]]) * ACC_WIDTH'(coef);
  assign acc_sum = acc + term;
  assign rounded = (acc_sum + ACC_WIDTH'(2 ** (COEF_FRAC - 1))) >>> COEF_FRAC;

  always_comb begin
    y_sat = OUT_WIDTH'(rounded);
    if (rounded > SAT_MAX)      y_sat = OUT_WIDTH'(SAT_MAX);
    else if (rounded < SAT_MIN) y_sat = OUT_WIDTH'(SAT_MIN);
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      fetch_addr <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_index  <= '0;
      done       <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
      for (int i = 0; i < DCT8_N; i++) x[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD;
            busy       <= 1'b1;
            fetch_addr <= '0;
            out_index  <= '0;
            cnt        <= '0;
            acc        <= '0;
          end
        end
        LOAD: begin
          // Buffer read latency is one cycle: data for address cnt-1 arrives now.
          if (cnt != 4'd0) x[cnt[2:0] - 3'd1] <= sample_in;
          if (cnt < 4'd7) fetch_addr <= fetch_addr + 3'd1;
          if (cnt == 4'd8) begin
            state <= MAC;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        MAC: begin
          acc <= acc_sum;
          if (cnt == 4'd7) begin
            acc       <= '0;
            out_data  <= y_sat;
            out_valid <= 1'b1;
            state     <= EMIT;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_index == 3'd7) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              out_index <= out_index + 3'd1;
              state     <= MAC;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dct8_engine.sv
// Self-checking bench for dct8_engine: table vectors, backpressure, ignored
// start, mid-block reset and randomized blocks against a real-arithmetic DCT model.
module tb_dct8_engine;

  localparam int IW = 8;
  localparam int OW = 16;
  localparam int CF = 12;

  logic                 clock = 1'b0;
  logic                 nreset = 1'b0;
  logic                 start = 1'b0;
  logic                 out_ready = 1'b0;
  logic                 busy, fetch_clk, out_valid, done;
  logic [2:0]           fetch_addr, out_index;
  logic [IW-1:0]        fetch_data;
  logic signed [OW-1:0] out_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [IW-1:0] mem [8];

  int  got_y   [8];
  int  got_k   [8];
  int  got_cyc [8];
  int  n_out, done_cnt, done_cyc, stall_cnt;

  typedef struct {
    logic [63:0] samples;
    int          y0;
    int          y1;
  } vec_t;

  dct8_engine #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .COEF_FRAC(CF)) dut (
    .clock      (clock),
    .nreset     (nreset),
    .start      (start),
    .busy       (busy),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .fetch_clk  (fetch_clk),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .done       (done)
  );

  always #5 clock = ~clock;

  // Source buffer with one-cycle registered read.
  always @(posedge clock) begin
    cyc        <= cyc + 1;
    fetch_data <= mem[fetch_addr];
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint coef_ref(input int k, input int n);
    real ck, v;
    ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
    v  = (2.0 ** CF) * ck / 2.0 * $cos((2.0 * n + 1.0) * k * 3.141592653589793 / 16.0);
    return longint'($floor(v + 0.5));
  endfunction

  function automatic longint sample_val(input logic [IW-1:0] raw);
`ifdef DCT8_LEVEL_SHIFT_EN
    return longint'(raw) - longint'(2 ** (IW - 1));
`else
    return longint'($signed(raw));
`endif
  endfunction

  function automatic longint model_y(input int k);
    longint acc, q, y, lim;
    acc = 0;
    for (int n = 0; n < 8; n++) acc += sample_val(mem[n]) * coef_ref(k, n);
    q = acc + longint'(2 ** (CF - 1));
    y = q / longint'(2 ** CF);
    if ((q % longint'(2 ** CF)) != 0 && q < 0) y = y - 1;
    lim = (longint'(1) << (OW - 1));
    if (y > lim - 1) y = lim - 1;
    if (y < -lim)    y = -lim;
    return y;
  endfunction

  // ---------------- block driver / monitor ----------------
  task automatic run_block(input int stall_k, input int stall_len, input bit rand_ready,
                           input int start2_at, input int reset_at);
    int cyc0, idx, stalled;
    bit holding;
    logic signed [OW-1:0] held;
    n_out = 0; done_cnt = 0; done_cyc = -1; stall_cnt = 0; stalled = 0; holding = 0; held = '0;
    for (int i = 0; i < 8; i++) begin got_y[i] = 0; got_k[i] = -1; got_cyc[i] = -1; end
    @(negedge clock);
    start = 1'b1; out_ready = 1'b1; cyc0 = cyc;
    @(negedge clock);
    start = 1'b0;
    for (int t = 0; t < 400; t++) begin
      idx = cyc - cyc0;
      start = (idx == start2_at);
      if (idx == reset_at) begin
        nreset = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_fetch_addr", fetch_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_done", done, 0);
        start = 1'b0;
        for (int r = 0; r < 3; r++) begin
          @(negedge clock);
          chk("rst_hold_done", done, 0);
        end
        chk("rst_hold_busy", busy, 0);
        nreset = 1'b1;
        return;
      end
      out_ready = 1'b1;
      if (out_valid) begin
        if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
        else if (int'(out_index) == stall_k && stalled < stall_len) begin
          out_ready = 1'b0;
          stalled++;
        end
        if (holding) chk($sformatf("stable_y%0d", out_index), out_data, held);
        else if (n_out < 8) got_cyc[n_out] = idx;
        held = out_data;
        holding = 1;
        if (!out_ready) stall_cnt++;
        else begin
          if (n_out < 8) begin
            got_y[n_out] = int'(out_data);
            got_k[n_out] = int'(out_index);
            $display("out y[%0d]=%0d first valid cycle %0d", out_index, out_data, got_cyc[n_out]);
          end
          n_out++;
          holding = 0;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = idx;
      end
      if (done_cnt > 0 && idx >= done_cyc + 20) break;
      @(negedge clock);
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic check_block(input string tag, input int exp_done);
    chk({tag, "_n_out"}, n_out, 8);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_cyc"}, done_cyc, exp_done);
    chk({tag, "_busy_after"}, busy, 0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_k%0d_index", tag, k), got_k[k], k);
      chk($sformatf("%s_y%0d", tag, k), got_y[k], model_y(k));
    end
  endtask

  task automatic load_random();
    for (int n = 0; n < 8; n++) mem[n] = IW'($urandom_range(0, 255));
  endtask

  vec_t vecs [3];

  initial begin
`ifdef DCT8_LEVEL_SHIFT_EN
    vecs[0] = '{samples: {8{8'd128}}, y0: 0, y1: 0};
    vecs[1] = '{samples: {8{8'd255}}, y0: 359, y1: 0};
    vecs[2] = '{samples: {{7{8'd128}}, 8'd228}, y0: 35, y1: 49};
`else
    vecs[0] = '{samples: {8{8'd0}}, y0: 0, y1: 0};
    vecs[1] = '{samples: {8{8'd127}}, y0: 359, y1: 0};
    vecs[2] = '{samples: {{7{8'd0}}, 8'd100}, y0: 35, y1: 49};
`endif
    for (int n = 0; n < 8; n++) mem[n] = '0;

    // Reset state
    repeat (3) @(negedge clock);
    chk("reset_busy", busy, 0);
    chk("reset_fetch_addr", fetch_addr, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_index", out_index, 0);
    chk("reset_done", done, 0);
    chk("fetch_clk_low", fetch_clk, clock);
    nreset = 1'b1;
    @(posedge clock); #1;
    chk("fetch_clk_high", fetch_clk, clock);

    // Table-driven vectors, zero backpressure
    for (int v = 0; v < 3; v++) begin
      for (int n = 0; n < 8; n++) mem[n] = vecs[v].samples[8*n +: 8];
      run_block(-1, 0, 1'b0, -1, -1);
      check_block($sformatf("vec%0d", v), 82);
      chk($sformatf("vec%0d_y0_fixed", v), got_y[0], vecs[v].y0);
      chk($sformatf("vec%0d_y1_fixed", v), got_y[1], vecs[v].y1);
      chk($sformatf("vec%0d_y0_cycle", v), got_cyc[0], 18);
      chk($sformatf("vec%0d_y3_cycle", v), got_cyc[3], 45);
      chk($sformatf("vec%0d_y7_cycle", v), got_cyc[7], 81);
      chk($sformatf("vec%0d_fetch_hold", v), fetch_addr, 7);
    end

    // Backpressure: out_ready low 10 cycles at the y[0] EMIT
    load_random();
    run_block(0, 10, 1'b0, -1, -1);
    check_block("stall", 92);
    chk("stall_y0_cycle", got_cyc[0], 18);
    chk("stall_y1_cycle", got_cyc[1], 37);
    chk("stall_cycles", stall_cnt, 10);

    // Second start while busy is ignored
    load_random();
    run_block(-1, 0, 1'b0, 40, -1);
    check_block("start2", 82);

    // Reset during MAC of k=3, then a full block
    load_random();
    run_block(-1, 0, 1'b0, -1, 40);
    load_random();
    run_block(-1, 0, 1'b0, -1, -1);
    check_block("post_reset", 82);

    // Randomized samples and backpressure
    for (int b = 0; b < 6; b++) begin
      load_random();
      run_block(-1, 0, 1'b1, -1, -1);
      check_block($sformatf("rand%0d", b), 82 + stall_cnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
